// File: rtl/debounce_sync.sv
// Input conditioner: synchronises a raw asynchronous level into the clk domain,
// debounces it with a stability-counter FSM and emits single-cycle edge pulses.
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 10,
  parameter int CNT_WIDTH   = 4
) (
  input  logic clk,
  input  logic reset_in,
  input  logic d_in,
  output logic q_out,
  output logic rise_out,
  output logic fall_out,
  output logic busy_out
);

  localparam logic [1:0] LOW       = 2'd0;
  localparam logic [1:0] RISE_WAIT = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] FALL_WAIT = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [1:0]             state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   q_nxt, rise_nxt, fall_nxt;

  // Plain flop chain: any logic between stages would defeat metastability settling.
  always_ff @(posedge clk) begin
    if (reset_in) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], d_in};
  end

  assign s = sync[SYNC_STAGES-1];

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    q_nxt     = q_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (s) begin
          state_nxt = RISE_WAIT;
          cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_nxt = LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          q_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_nxt = FALL_WAIT;
          cnt_nxt   = CNT_WIDTH'(1);
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          q_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = LOW;
        q_nxt     = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state    <= LOW;
      cnt      <= '0;
      q_out    <= 1'b0;
      rise_out <= 1'b0;
      fall_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      q_out    <= q_nxt;
      rise_out <= rise_nxt;
      fall_out <= fall_nxt;
    end
  end

  assign busy_out = (state == RISE_WAIT) || (state == FALL_WAIT);

endmodule
